// File: rtl/booth_div.sv
// Sequential signed divider: restoring shift/subtract on magnitudes, one quotient
// bit per cycle, followed by a single sign-correction cycle.
module booth_div #(
    parameter int width = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [width-1:0] dividend,
    input  logic [width-1:0] divisor,
    output logic [width-1:0] quotient,
    output logic [width-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(width + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [width-1:0] rem_q, rem_d;
    logic [width-1:0] dvd_q, dvd_d;
    logic [width:0]   dvs_q, dvs_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic [width-1:0] quotient_q, quotient_d;
    logic [width-1:0] remainder_q, remainder_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [width:0]   rem_sh;
    logic             ge;

    // One extra bit so the magnitude of the most negative operand is exact.
    function automatic logic [width:0] abs_ext(input logic [width-1:0] x);
        abs_ext = x[width-1] ? -{x[width-1], x} : {x[width-1], x};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            neg_q_q     <= neg_q_d;
            neg_r_q     <= neg_r_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        neg_q_d     = neg_q_q;
        neg_r_d     = neg_r_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;

        // Partial remainder never exceeds the divisor magnitude, so width bits hold it.
        rem_sh = {rem_q, dvd_q[width-1]};
        ge     = (rem_sh >= dvs_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        done_d      = 1'b1;
                    end else begin
                        dvd_d   = width'(abs_ext(dividend));
                        dvs_d   = abs_ext(divisor);
                        rem_d   = '0;
                        cnt_d   = '0;
                        neg_r_d = dividend[width-1];
                        neg_q_d = dividend[width-1] ^ divisor[width-1];
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = ge ? width'(rem_sh - dvs_q) : rem_sh[width-1:0];
                dvd_d = {dvd_q[width-2:0], ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(width - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quotient_d  = neg_q_q ? -dvd_q : dvd_q;
                remainder_d = neg_r_q ? -rem_q : rem_q;
                dbz_d       = 1'b0;
                done_d      = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_booth_div.sv
// Directed checks of booth_div (width=6) against hand-computed quotients/remainders.
module tb_booth_div;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [5:0] dividend;
    logic [5:0] divisor;
    logic [5:0] quotient;
    logic [5:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    int pass_cnt = 0;
    int total_cnt = 0;

    booth_div #(.width(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Pulses start for one edge, scrambles the operands after capture, then waits for done.
    task automatic run_div(input logic [5:0] a, input logic [5:0] b,
                           input logic [5:0] eq, input logic [5:0] er,
                           input logic edbz, input int elat, input string name);
        int lat;
        int bcnt;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 6'h2a;
        divisor  = 6'h15;
        lat  = 0;
        bcnt = 0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        total_cnt++;
        if (lat !== elat) $display("FAIL %s latency: got %0d expected %0d", name, lat, elat);
        else pass_cnt++;
        total_cnt++;
        if (quotient !== eq) $display("FAIL %s quotient: got %b expected %b", name, quotient, eq);
        else pass_cnt++;
        total_cnt++;
        if (remainder !== er) $display("FAIL %s remainder: got %b expected %b", name, remainder, er);
        else pass_cnt++;
        total_cnt++;
        if (div_by_zero !== edbz) $display("FAIL %s div_by_zero: got %b expected %b", name, div_by_zero, edbz);
        else pass_cnt++;
        total_cnt++;
        if (bcnt !== elat) $display("FAIL %s busy cycles: got %0d expected %0d", name, bcnt, elat);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({quotient, remainder, busy, done, div_by_zero} !== 15'd0)
            $display("FAIL reset outputs: got q=%b r=%b busy=%b done=%b dbz=%b expected all zero",
                     quotient, remainder, busy, done, div_by_zero);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        run_div(6'd20, 6'd3, 6'd6, 6'd2, 1'b0, 7, "pos_pos");
        run_div(6'b101100, 6'd3, 6'b111010, 6'b111110, 1'b0, 7, "neg_pos");
        run_div(6'd20, 6'(-3), 6'(-6), 6'd2, 1'b0, 7, "pos_neg");
        run_div(6'(-20), 6'(-3), 6'd6, 6'(-2), 1'b0, 7, "neg_neg");
    endtask

    task automatic test_div_zero();
        run_div(6'd7, 6'd0, 6'b111111, 6'd7, 1'b1, 0, "div_zero");
        @(posedge clk);
        #1;
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL div_zero pulse: got done=%b busy=%b expected done=0 busy=0", done, busy);
        else pass_cnt++;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (quotient !== 6'b111111 || remainder !== 6'd7 || div_by_zero !== 1'b1)
            $display("FAIL div_zero hold: got q=%b r=%b dbz=%b expected q=111111 r=000111 dbz=1",
                     quotient, remainder, div_by_zero);
        else pass_cnt++;
    endtask

    task automatic test_extremes();
        run_div(6'b100000, 6'b111111, 6'b100000, 6'd0, 1'b0, 7, "min_by_m1");
        run_div(6'b100000, 6'd5, 6'(-6), 6'(-2), 1'b0, 7, "min_by_5");
        run_div(6'd31, 6'd1, 6'd31, 6'd0, 1'b0, 7, "max_by_1");
        run_div(6'd3, 6'(-32), 6'd0, 6'd3, 1'b0, 7, "small_by_min");
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        dividend = 6'd13;
        divisor  = 6'd4;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            lat++;
        end
        @(negedge clk);
        dividend = 6'd9;
        divisor  = 6'd2;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat++;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        total_cnt++;
        if (lat !== 7 || quotient !== 6'd3 || remainder !== 6'd1)
            $display("FAIL ignore_start: got lat=%0d q=%0d r=%0d expected lat=7 q=3 r=1",
                     lat, quotient, remainder);
        else pass_cnt++;
        // Still inside the done cycle: request the next division immediately.
        dividend = 6'd9;
        divisor  = 6'd2;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        total_cnt++;
        if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL b2b accept: got busy=%b done=%b expected busy=1 done=0", busy, done);
        else pass_cnt++;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        total_cnt++;
        if (lat !== 7 || quotient !== 6'd4 || remainder !== 6'd1)
            $display("FAIL b2b result: got lat=%0d q=%0d r=%0d expected lat=7 q=4 r=1",
                     lat, quotient, remainder);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int dcnt;
        run_div(6'd7, 6'd0, 6'b111111, 6'd7, 1'b1, 0, "pre_reset_zero");
        @(negedge clk);
        dividend = 6'd20;
        divisor  = 6'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({quotient, remainder, busy, done, div_by_zero} !== 15'd0)
            $display("FAIL mid reset outputs: got q=%b r=%b busy=%b done=%b dbz=%b expected all zero",
                     quotient, remainder, busy, done, div_by_zero);
        else pass_cnt++;
        dcnt = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done || busy) dcnt++;
        end
        total_cnt++;
        if (dcnt !== 0) $display("FAIL abort no_done: got %0d active cycles expected 0", dcnt);
        else pass_cnt++;
        run_div(6'd15, 6'd5, 6'd3, 6'd0, 1'b0, 7, "after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_extremes();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/booth_div.md
BOOTH_DIV -- requirements
Module: booth_div

Interface
REQ-001 Parameter width SHALL be declared as: width, default 6, operand bit width (signed two's complement).
REQ-002 Port clk SHALL be: clk  input  1  system clock, all state updates on rising edge.
REQ-003 Port rst_n SHALL be: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port start SHALL be: start  input  1  request to begin a division, sampled on clk rising edge.
REQ-005 Port dividend SHALL be: dividend  input  width  signed dividend, captured with start.
REQ-006 Port divisor SHALL be: divisor  input  width  signed divisor, captured with start.
REQ-007 Port quotient SHALL be: quotient  output  width  signed quotient, registered.
REQ-008 Port remainder SHALL be: remainder  output  width  signed remainder, registered.
REQ-009 Port busy SHALL be: busy  output  1  high while a division is in progress.
REQ-010 Port done SHALL be: done  output  1  one-cycle pulse when quotient/remainder become valid.
REQ-011 Port div_by_zero SHALL be: div_by_zero  output  1  high with done when the captured divisor was zero.

Function
REQ-012 The block SHALL implement signed division: quotient truncated toward zero, remainder sign equal to dividend sign, dividend = quotient*divisor + remainder.
REQ-013 The FSM SHALL have states IDLE, CALC and FIX; busy = 1 exactly in CALC and FIX.
REQ-014 In IDLE, start=1 with divisor!=0 SHALL capture |dividend|, |divisor| and both sign bits, clear an iteration counter, and enter CALC on the same edge.
REQ-015 CALC SHALL run exactly width cycles of restoring shift/subtract on magnitudes (one quotient bit per cycle, MSB first), then enter FIX.
REQ-016 FIX SHALL apply sign correction (negate quotient if signs differ, negate remainder if dividend negative), load quotient/remainder registers, assert done for one cycle, and return to IDLE.
REQ-017 Latency SHALL be width+1 clock edges from the start-sampling edge to done high (7 for width=6).
REQ-018 Internal magnitude arithmetic SHALL use width+1 bits so |-2^(width-1)| is represented without overflow.
REQ-019 dividend = -2^(width-1) with divisor = -1 SHALL yield quotient = -2^(width-1) (wrapped) and remainder = 0, div_by_zero = 0.
REQ-020 In IDLE, start=1 with divisor=0 SHALL on that edge set quotient = all ones, remainder = dividend, div_by_zero = 1, done = 1 for one cycle, staying in IDLE.
REQ-021 start while busy=1 SHALL be ignored; operands are not re-captured and the running division is unaffected.
REQ-022 start=1 in the cycle done is high (state IDLE) SHALL be accepted normally (back-to-back operation).
REQ-023 quotient, remainder and div_by_zero SHALL hold their values until the next done pulse; div_by_zero SHALL clear on a done from a non-zero-divisor division.
REQ-024 Operand input changes after the capture edge SHALL NOT affect the result.

Reset
REQ-025 rst_n=0 SHALL asynchronously force state IDLE, counter 0, quotient 0, remainder 0, busy 0, done 0, div_by_zero 0.
REQ-026 Reset asserted mid-operation SHALL abort the division with no done pulse; the first start after rst_n rises SHALL be processed normally.

Verification
REQ-027 width=6, dividend=20, divisor=3, start pulse -> done 7 edges later, quotient=6, remainder=2, div_by_zero=0, busy high for exactly 7 cycles.
REQ-028 dividend=-20 (6'b101100), divisor=3 -> quotient=-6 (6'b111010), remainder=-2 (6'b111110); dividend=20, divisor=-3 -> quotient=-6, remainder=2.
REQ-029 dividend=7, divisor=0 -> done one edge after start, quotient=6'b111111, remainder=7, div_by_zero=1, busy never high.
REQ-030 dividend=-32, divisor=-1 -> quotient=6'b100000, remainder=0; dividend=-32, divisor=5 -> quotient=-6, remainder=-2.
REQ-031 Start 13/4, re-pulse start with 9/2 during CALC -> single done, quotient=3, remainder=1; start 9/2 in the done cycle -> second done 7 edges later, quotient=4, remainder=1.
REQ-032 Drop rst_n at CALC cycle 3 -> all outputs 0 immediately, no done; release, start 15/5 -> quotient=3, remainder=0.
